// File: rtl/lv_bist_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : lv_bist_ctrl_if
// Description : Control/status bundle between the LV BIST sequencer and its
//               requester plus the LV logic BIST engine result lines.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
interface lv_bist_ctrl_if;
  logic       i_bist_start;
  logic       i_bist_abort;
  logic       i_lv_bist_done;
  logic       i_owt_bist_rult;
  logic       i_scan_reg_bist_rult;
  logic       i_hv_intb_bist_rult;
  logic       o_bist_en;
  logic       o_bist_busy;
  logic       o_bist_done_pulse;
  logic       o_bist_pass;
  logic       o_bist_fail;
  logic [2:0] o_bist_fail_code;
  logic [1:0] o_bist_retry_cnt;

  // Requester / engine side: drives requests and results, observes status.
  modport master (
    output i_bist_start, i_bist_abort, i_lv_bist_done,
           i_owt_bist_rult, i_scan_reg_bist_rult, i_hv_intb_bist_rult,
    input  o_bist_en, o_bist_busy, o_bist_done_pulse, o_bist_pass,
           o_bist_fail, o_bist_fail_code, o_bist_retry_cnt
  );

  // Sequencer side.
  modport slave (
    input  i_bist_start, i_bist_abort, i_lv_bist_done,
           i_owt_bist_rult, i_scan_reg_bist_rult, i_hv_intb_bist_rult,
    output o_bist_en, o_bist_busy, o_bist_done_pulse, o_bist_pass,
           o_bist_fail, o_bist_fail_code, o_bist_retry_cnt
  );
endinterface
`default_nettype wire

// File: rtl/lv_bist_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : lv_bist_ctrl
// Description : Sequencer for the LV logic BIST: settle, run with a guard
//               timer, evaluate the three check results, retry on failure
//               and latch a sticky pass/fail verdict with a fail code.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
module lv_bist_ctrl #(
  parameter int CLK_M      = 48,
  parameter int SETTLE_CYC = 8,
  parameter int GAP_CYC    = 16,
  parameter int MAX_RETRY  = 1,
  parameter int GUARD_TH   = 2500 * CLK_M
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  lv_bist_ctrl_if.slave bus
);

  // SETTLE and GAP never overlap, so one phase counter serves both.
  localparam int PH_MAX = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int GD_W   = $clog2(GUARD_TH + 1);

  localparam logic [PH_W-1:0] SETTLE_LAST  = PH_W'(SETTLE_CYC - 1);
  localparam logic [PH_W-1:0] GAP_LAST     = PH_W'(GAP_CYC - 1);
  localparam logic [GD_W-1:0] GUARD_LAST   = GD_W'(GUARD_TH - 1);
  localparam logic [2:0]      CODE_TIMEOUT = 3'b111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    RUN    = 3'd2,
    EVAL   = 3'd3,
    GAP    = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PH_W-1:0] phase_cnt;
  logic [GD_W-1:0] guard_cnt;

  logic            bist_en;
  logic            bist_busy;
  logic            done_pulse;
  logic            pass;
  logic            fail;
  logic [2:0]      fail_code;
  logic [1:0]      retry_cnt;

  logic            start_acc;
  logic            retry_inc;
  logic            fin_load;
  logic            fin_pass;
  logic [2:0]      fin_code;
  logic            run_failed;
  logic [2:0]      run_code;
  logic [2:0]      eval_code;
  logic            retry_avail;

  // A zero result bit means that check failed.
  assign eval_code   = {~bus.i_hv_intb_bist_rult, ~bus.i_scan_reg_bist_rult,
                        ~bus.i_owt_bist_rult};
  assign retry_avail = (int'(retry_cnt) < MAX_RETRY);

  // Next-state and sequencing decisions; abort overrides everything last.
  always_comb begin
    state_nxt  = state;
    start_acc  = 1'b0;
    retry_inc  = 1'b0;
    fin_load   = 1'b0;
    fin_pass   = 1'b0;
    fin_code   = 3'b000;
    run_failed = 1'b0;
    run_code   = 3'b000;

    case (state)
      IDLE: begin
        if (bus.i_bist_start) begin
          start_acc = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (phase_cnt == SETTLE_LAST) state_nxt = RUN;
      end
      RUN: begin
        // Done wins over a coincident guard terminal count.
        if (bus.i_lv_bist_done) begin
          state_nxt = EVAL;
        end else if (guard_cnt == GUARD_LAST) begin
          run_failed = 1'b1;
          run_code   = CODE_TIMEOUT;
        end
      end
      EVAL: begin
        if (eval_code == 3'b000) begin
          state_nxt = FINISH;
          fin_load  = 1'b1;
          fin_pass  = 1'b1;
        end else begin
          run_failed = 1'b1;
          run_code   = eval_code;
        end
      end
      GAP: begin
        if (phase_cnt == GAP_LAST) state_nxt = SETTLE;
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (run_failed) begin
      if (retry_avail) begin
        retry_inc = 1'b1;
        state_nxt = GAP;
      end else begin
        state_nxt = FINISH;
        fin_load  = 1'b1;
        fin_code  = run_code;
      end
    end

    if (bus.i_bist_abort) begin
      state_nxt = IDLE;
      start_acc = 1'b0;
      retry_inc = 1'b0;
      fin_load  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Phase and guard counters; both restart whenever the state changes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_cnt <= '0;
      guard_cnt <= '0;
    end else begin
      if (state_nxt != state)                  phase_cnt <= '0;
      else if (state == SETTLE || state == GAP) phase_cnt <= phase_cnt + 1'b1;

      if (state == RUN && state_nxt == RUN) guard_cnt <= guard_cnt + 1'b1;
      else                                  guard_cnt <= '0;
    end
  end

  // Registered outputs, computed from the upcoming state so they align with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bist_en    <= 1'b0;
      bist_busy  <= 1'b0;
      done_pulse <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      fail_code  <= 3'b000;
      retry_cnt  <= 2'd0;
    end else begin
      bist_en    <= (state_nxt == RUN) || (state_nxt == EVAL);
      bist_busy  <= (state_nxt != IDLE);
      done_pulse <= fin_load;
      if (start_acc) begin
        pass      <= 1'b0;
        fail      <= 1'b0;
        fail_code <= 3'b000;
        retry_cnt <= 2'd0;
      end else begin
        if (fin_load) begin
          pass      <= fin_pass;
          fail      <= ~fin_pass;
          fail_code <= fin_code;
        end
        if (retry_inc && retry_cnt != 2'd3) retry_cnt <= retry_cnt + 1'b1;
      end
    end
  end

  assign bus.o_bist_en         = bist_en;
  assign bus.o_bist_busy       = bist_busy;
  assign bus.o_bist_done_pulse = done_pulse;
  assign bus.o_bist_pass       = pass;
  assign bus.o_bist_fail       = fail;
  assign bus.o_bist_fail_code  = fail_code;
  assign bus.o_bist_retry_cnt  = retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lv_bist_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_lv_bist_ctrl
// Description : Self-checking bench for lv_bist_ctrl with a sequence-level
//               reference model (expected o_bist_en waveform and verdict).
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_lv_bist_ctrl;

  localparam int CLK_M      = 1;
  localparam int SETTLE_CYC = 8;
  localparam int GAP_CYC    = 16;
  localparam int MAX_RETRY  = 1;
  localparam int GUARD_TH   = 2500 * CLK_M;
  localparam int BUDGET     = 20000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  lv_bist_ctrl_if bus ();

  lv_bist_ctrl #(
    .CLK_M      (CLK_M),
    .SETTLE_CYC (SETTLE_CYC),
    .GAP_CYC    (GAP_CYC),
    .MAX_RETRY  (MAX_RETRY),
    .GUARD_TH   (GUARD_TH)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-run behaviour of the engine: done delay in RUN cycles (0 = never)
  // and the fail code the three result lines should encode.
  int         run_dly  [4];
  logic [2:0] run_code [4];

  // Model outputs.
  bit         exp_en [$];
  bit         exp_pass;
  logic [2:0] exp_code;
  int         exp_retry;

  // Expected sequence: each run is SETTLE low cycles, then en high for the
  // RUN cycles plus one EVAL cycle (timeout: GUARD_TH RUN cycles, no EVAL);
  // failures with retries left add a GAP; one low FINISH cycle ends it.
  function automatic void build_model();
    int         retries;
    bit         to;
    int         high;
    logic [2:0] code;
    retries = 0;
    exp_en.delete();
    for (int r = 0; r < 4; r++) begin
      to   = (run_dly[r] == 0) || (run_dly[r] > GUARD_TH);
      high = to ? GUARD_TH : run_dly[r] + 1;
      code = to ? 3'b111 : run_code[r];
      repeat (SETTLE_CYC) exp_en.push_back(1'b0);
      repeat (high)       exp_en.push_back(1'b1);
      if (code == 3'b000) begin
        exp_pass = 1'b1; exp_code = 3'b000; exp_retry = retries;
        break;
      end
      if (retries < MAX_RETRY) begin
        retries++;
        repeat (GAP_CYC) exp_en.push_back(1'b0);
      end else begin
        exp_pass = 1'b0; exp_code = code; exp_retry = retries;
        break;
      end
    end
    exp_en.push_back(1'b0);
  endfunction

  task automatic set_results(input int r);
    bus.i_owt_bist_rult      = ~run_code[r][0];
    bus.i_scan_reg_bist_rult = ~run_code[r][1];
    bus.i_hv_intb_bist_rult  = ~run_code[r][2];
  endtask

  // Runs one full sequence from a start pulse and checks it against the model.
  // extra_start: cycle number (after acceptance) at which a second start
  // pulse is sent while busy; 0 = none.
  task automatic run_seq(input string name, input int extra_start);
    bit got_en [$];
    int c        = 0;
    int run      = -1;
    int k        = 0;
    bit prev_en  = 1'b0;
    bit en;
    bit finished = 1'b0;
    bit mutex_bad = 1'b0;
    bit busy_bad  = 1'b0;
    int first_bad = -1;
    int post_pulses = 0;
    bit post_bad  = 1'b0;

    build_model();
    @(negedge clk);
    set_results(0);
    bus.i_bist_start = 1'b1;
    @(negedge clk);
    bus.i_bist_start = 1'b0;

    checks++;
    if (bus.o_bist_pass !== 1'b0 || bus.o_bist_fail !== 1'b0 ||
        bus.o_bist_fail_code !== 3'b000 || bus.o_bist_retry_cnt !== 2'd0)
      $display("FAIL %s clear_on_start: pass=%b fail=%b code=%b retry=%0d, required all 0",
               name, bus.o_bist_pass, bus.o_bist_fail, bus.o_bist_fail_code, bus.o_bist_retry_cnt);

    while (c < BUDGET) begin
      c++;
      en = bus.o_bist_en;
      got_en.push_back(en);
      if (bus.o_bist_pass && bus.o_bist_fail) mutex_bad = 1'b1;
      if (bus.o_bist_busy !== 1'b1) busy_bad = 1'b1;
      if (bus.o_bist_done_pulse === 1'b1) begin
        finished = 1'b1;
        break;
      end
      if (en && !prev_en) begin
        run++;
        k = 1;
        set_results(run);
      end else if (en) begin
        k++;
      end
      prev_en = en;
      bus.i_lv_bist_done = 1'b0;
      if (en && run >= 0) begin
        if (k == run_dly[run]) bus.i_lv_bist_done = 1'b1;
      end
      bus.i_bist_start = (c == extra_start);
      @(negedge clk);
    end
    bus.i_lv_bist_done = 1'b0;
    bus.i_bist_start   = 1'b0;

    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s done_pulse: none within %0d cycles, required one", name, BUDGET);
    end

    checks++;
    for (int i = 0; i < exp_en.size(); i++) begin
      if (i >= got_en.size() || got_en[i] !== exp_en[i]) begin
        first_bad = i;
        break;
      end
    end
    if (first_bad >= 0 || got_en.size() != exp_en.size()) begin
      errors++;
      $display("FAIL %s en_waveform: got %0d cycles, required %0d, first difference at cycle %0d",
               name, got_en.size(), exp_en.size(), first_bad + 1);
    end

    checks++;
    if (bus.o_bist_pass !== exp_pass || bus.o_bist_fail !== !exp_pass) begin
      errors++;
      $display("FAIL %s verdict: pass=%b fail=%b, required pass=%b fail=%b",
               name, bus.o_bist_pass, bus.o_bist_fail, exp_pass, !exp_pass);
    end

    checks++;
    if (bus.o_bist_fail_code !== exp_code) begin
      errors++;
      $display("FAIL %s fail_code: got %b, required %b", name, bus.o_bist_fail_code, exp_code);
    end

    checks++;
    if (int'(bus.o_bist_retry_cnt) != exp_retry) begin
      errors++;
      $display("FAIL %s retry_cnt: got %0d, required %0d", name, bus.o_bist_retry_cnt, exp_retry);
    end

    checks++;
    if (mutex_bad || busy_bad) begin
      errors++;
      $display("FAIL %s busy_mutex: busy_dropped=%b pass_and_fail=%b, required 0 0",
               name, busy_bad, mutex_bad);
    end

    // After FINISH: idle, no further pulses, verdict held.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.o_bist_done_pulse) post_pulses++;
      if (bus.o_bist_busy !== 1'b0 || bus.o_bist_pass !== exp_pass ||
          bus.o_bist_fail !== !exp_pass || bus.o_bist_fail_code !== exp_code) post_bad = 1'b1;
    end
    checks++;
    if (post_pulses != 0 || post_bad) begin
      errors++;
      $display("FAIL %s post_finish: extra_pulses=%0d hold_broken=%b, required 0 0",
               name, post_pulses, post_bad);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_bist_en !== 1'b0 || bus.o_bist_busy !== 1'b0 || bus.o_bist_done_pulse !== 1'b0 ||
        bus.o_bist_pass !== 1'b0 || bus.o_bist_fail !== 1'b0 ||
        bus.o_bist_fail_code !== 3'b000 || bus.o_bist_retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: en=%b busy=%b pulse=%b pass=%b fail=%b code=%b retry=%0d, required all 0",
               bus.o_bist_en, bus.o_bist_busy, bus.o_bist_done_pulse, bus.o_bist_pass,
               bus.o_bist_fail, bus.o_bist_fail_code, bus.o_bist_retry_cnt);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean_pass();
    run_dly[0] = 100; run_code[0] = 3'b000;
    run_seq("clean_pass", 0);
  endtask

  task automatic test_fail_then_pass();
    run_dly[0] = $urandom_range(20, 200); run_code[0] = 3'b001;
    run_dly[1] = $urandom_range(20, 200); run_code[1] = 3'b000;
    run_seq("fail_then_pass", 0);
  endtask

  task automatic test_double_fail();
    run_dly[0] = $urandom_range(20, 200); run_code[0] = 3'b110;
    run_dly[1] = $urandom_range(20, 200); run_code[1] = 3'b110;
    run_seq("double_fail", 0);
  endtask

  task automatic test_timeout();
    run_dly[0] = 0; run_code[0] = 3'b000;
    run_dly[1] = 0; run_code[1] = 3'b000;
    run_seq("timeout", 0);
  endtask

  task automatic test_done_at_guard();
    run_dly[0] = GUARD_TH; run_code[0] = 3'b000;
    run_seq("done_at_guard", 0);
  endtask

  task automatic test_busy_start();
    run_dly[0] = $urandom_range(30, 120); run_code[0] = 3'b010;
    run_dly[1] = $urandom_range(30, 120); run_code[1] = 3'b000;
    run_seq("busy_start", SETTLE_CYC + 5);
  endtask

  task automatic test_abort_in_run();
    int  waited = 0;
    int  pulses = 0;
    bit  bad    = 1'b0;
    run_code[0] = 3'b000;
    set_results(0);
    @(negedge clk);
    bus.i_bist_start = 1'b1;
    @(negedge clk);
    bus.i_bist_start = 1'b0;
    while (bus.o_bist_en !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    repeat (5) @(negedge clk);
    bus.i_bist_abort = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_bist_en !== 1'b0 || bus.o_bist_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_next_cycle: en=%b busy=%b, required 0 0", bus.o_bist_en, bus.o_bist_busy);
    end
    bus.i_bist_abort = 1'b0;
    // Verdict stays as cleared by the accepted start.
    for (int i = 0; i < 40; i++) begin
      if (bus.o_bist_done_pulse) pulses++;
      if (bus.o_bist_busy !== 1'b0 || bus.o_bist_en !== 1'b0 || bus.o_bist_pass !== 1'b0 ||
          bus.o_bist_fail !== 1'b0 || bus.o_bist_fail_code !== 3'b000) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (pulses != 0 || bad) begin
      errors++;
      $display("FAIL abort_quiet: pulses=%0d state_broken=%b, required 0 0", pulses, bad);
    end
  endtask

  task automatic test_reset_mid_run();
    int waited = 0;
    int pulses = 0;
    bit bad    = 1'b0;
    run_code[0] = 3'b000;
    set_results(0);
    @(negedge clk);
    bus.i_bist_start = 1'b1;
    @(negedge clk);
    bus.i_bist_start = 1'b0;
    while (bus.o_bist_en !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_bist_en !== 1'b0 || bus.o_bist_busy !== 1'b0 || bus.o_bist_done_pulse !== 1'b0 ||
        bus.o_bist_pass !== 1'b0 || bus.o_bist_fail !== 1'b0 ||
        bus.o_bist_fail_code !== 3'b000 || bus.o_bist_retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_run: en=%b busy=%b pulse=%b pass=%b fail=%b, required all 0",
               bus.o_bist_en, bus.o_bist_busy, bus.o_bist_done_pulse, bus.o_bist_pass, bus.o_bist_fail);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_bist_done_pulse) pulses++;
      if (bus.o_bist_busy !== 1'b0 || bus.o_bist_pass !== 1'b0 || bus.o_bist_fail !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (pulses != 0 || bad) begin
      errors++;
      $display("FAIL reset_discard: pulses=%0d state_broken=%b, required 0 0", pulses, bad);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      for (int r = 0; r < 4; r++) begin
        run_dly[r]  = $urandom_range(1, 300);
        run_code[r] = ($urandom_range(0, 1) == 1) ? 3'b000 : 3'($urandom_range(1, 7));
      end
      run_seq("random", ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 40)) : 0);
    end
  endtask

  initial begin
    bus.i_bist_start         = 1'b0;
    bus.i_bist_abort         = 1'b0;
    bus.i_lv_bist_done       = 1'b0;
    bus.i_owt_bist_rult      = 1'b1;
    bus.i_scan_reg_bist_rult = 1'b1;
    bus.i_hv_intb_bist_rult  = 1'b1;
    for (int r = 0; r < 4; r++) begin
      run_dly[r]  = 50;
      run_code[r] = 3'b000;
    end

    test_reset();
    test_clean_pass();
    test_fail_then_pass();
    test_double_fail();
    test_timeout();
    test_abort_in_run();
    test_busy_start();
    test_done_at_guard();
    test_reset_mid_run();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lv_bist_ctrl.md
LV_BIST_CTRL -- requirements
Module: lv_bist_ctrl

Interface
REQ-001 Parameter CLK_M, default 48, clock cycles per microsecond, taken from the shared LV parameter header.
REQ-002 Parameter SETTLE_CYC, default 8, cycles o_bist_en is held low before each run.
REQ-003 Parameter GAP_CYC, default 16, cycles o_bist_en is held low between a failed run and its retry.
REQ-004 Parameter MAX_RETRY, default 1, maximum number of reruns after a failed run.
REQ-005 Parameter GUARD_TH, default 2500*CLK_M, maximum cycles in RUN before a timeout is declared.
REQ-006 i_clk  input  1  single block clock; all flops on its rising edge.
REQ-007 i_rst_n  input  1  asynchronous active-low reset.
REQ-008 i_bist_start  input  1  one-cycle start request.
REQ-009 i_bist_abort  input  1  level abort; returns the block to IDLE.
REQ-010 i_lv_bist_done  input  1  done flag from the LV logic BIST engine.
REQ-011 i_owt_bist_rult  input  1  OWT loopback result, 1 = pass.
REQ-012 i_scan_reg_bist_rult  input  1  scan-register check result, 1 = pass.
REQ-013 i_hv_intb_bist_rult  input  1  HV INTB check result, 1 = pass.
REQ-014 o_bist_en  output  1  enable to the BIST engine.
REQ-015 o_bist_busy  output  1  high in every state except IDLE.
REQ-016 o_bist_done_pulse  output  1  one-cycle pulse when a final verdict is latched.
REQ-017 o_bist_pass  output  1  sticky final verdict, pass.
REQ-018 o_bist_fail  output  1  sticky final verdict, fail.
REQ-019 o_bist_fail_code  output  3  bit0 = OWT fail, bit1 = scan fail, bit2 = INTB fail; 3'b111 = timeout.
REQ-020 o_bist_retry_cnt  output  2  number of retries used in the current or last sequence; saturates at 3.

Function
REQ-021 The FSM SHALL have the states IDLE, SETTLE, RUN, EVAL, GAP and FINISH, with the state register clocked by i_clk and reset to IDLE.
REQ-022 In IDLE, i_bist_start=1 SHALL, on the next edge:
- clear o_bist_pass, o_bist_fail, o_bist_fail_code and o_bist_retry_cnt;
- move the FSM to SETTLE.
REQ-023 In any state other than IDLE, i_bist_start SHALL be ignored.
REQ-024 SETTLE SHALL last exactly SETTLE_CYC cycles with o_bist_en=0, then move to RUN.
REQ-025 o_bist_en SHALL be a registered output that is 1 exactly while the state is RUN or EVAL.
REQ-026 RUN guard counter:
- it SHALL clear on entry to RUN and increment each RUN cycle;
- i_lv_bist_done=1 SHALL move the FSM to EVAL;
- if the counter reaches GUARD_TH-1 without i_lv_bist_done, the run SHALL be treated as failed with code 3'b111.
REQ-027 If i_lv_bist_done and the guard terminal count occur in the same cycle, done SHALL take priority and the FSM SHALL go to EVAL.
REQ-028 EVAL SHALL last 1 cycle and capture code = {~i_hv_intb_bist_rult, ~i_scan_reg_bist_rult, ~i_owt_bist_rult}.
REQ-029 After EVAL, if code==0 the FSM SHALL go to FINISH with verdict pass.
REQ-030 After a failed run (non-zero code or timeout):
- if o_bist_retry_cnt<MAX_RETRY, retry_cnt SHALL increment and the FSM SHALL go to GAP;
- otherwise the FSM SHALL go to FINISH with verdict fail and the last code.
REQ-031 GAP SHALL last GAP_CYC cycles with o_bist_en=0, then move to SETTLE.
REQ-032 FINISH SHALL last 1 cycle, during which:
- the verdict is latched into o_bist_pass/o_bist_fail;
- o_bist_fail_code is latched, and is 0 on pass;
- o_bist_done_pulse=1;
- the FSM then returns to IDLE.
REQ-033 o_bist_pass and o_bist_fail SHALL never both be 1, and SHALL hold their value in IDLE until the next accepted start.
REQ-034 i_bist_abort=1 in any state SHALL, on the next edge:
- force the FSM to IDLE with o_bist_en=0;
- produce no done pulse and leave the verdict outputs unchanged.
Abort SHALL have priority over every other transition.
REQ-035 Counter wrap rules:
- all cycle counters SHALL be sized with $clog2 of their terminal count +1 and SHALL never wrap;
- o_bist_retry_cnt SHALL saturate at 3.

Reset
REQ-036 Asynchronous assertion of i_rst_n=0 SHALL immediately set:
- the state to IDLE and all counters to 0;
- o_bist_en, o_bist_busy, o_bist_done_pulse, o_bist_pass and o_bist_fail to 0;
- o_bist_fail_code and o_bist_retry_cnt to 0.
REQ-037 Reset asserted mid-run SHALL discard the run, with no verdict and no done pulse.

Verification
REQ-038 Clean pass: start pulse, then done after 100 RUN cycles with all results =1 -> o_bist_en rises 8 cycles after start, one done pulse, pass=1, fail_code=0, retry_cnt=0.
REQ-039 Fail then pass: first run OWT result=0, second run all pass -> o_bist_en low for 16 cycles between runs, retry_cnt=1, pass=1, code=0.
REQ-040 Double fail: both runs scan result=0 and INTB result=0 -> fail=1, code=3'b110, retry_cnt=1, exactly one done pulse.
REQ-041 Timeout: done never asserted, with CLK_M=1 so GUARD_TH=2500 -> each run lasts 2500 RUN cycles, final fail=1, code=3'b111.
REQ-042 Abort in RUN plus repeated start: abort in RUN -> o_bist_en=0 next cycle, no done pulse, prior verdict kept; a start pulse while busy -> no effect.
REQ-043 Done coincident with guard terminal count, and reset mid-run: done at the guard terminal cycle -> EVAL taken, no timeout code; reset during RUN -> all outputs 0 at once.
